// File: rtl/unshift_streamer.sv
// Decoder-side bit unpacker: MSB-aligned window over a packed word stream.
// Optional simulation checks are compiled in with UNPACK_STREAMER_ASSERT_EN.
module unshift_streamer #(
  parameter int DATA_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          vld_i,
  output logic                          rdy_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          vld_o,
  input  logic [$clog2(DATA_W+1)-1:0]   consume_i,
  input  logic                          rdy_i,
  input  logic                          flush_i,
  output logic [$clog2(2*DATA_W+1)-1:0] fill_o,
  output logic                          idle_o
);
  localparam int FW = $clog2(2*DATA_W+1);
  localparam int CW = $clog2(DATA_W+1);
  localparam logic [FW-1:0] W_F  = FW'(DATA_W);
  localparam logic [FW-1:0] W2_F = FW'(2*DATA_W);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, FLUSH} st_e;

  logic [2*DATA_W-1:0] buf_q, buf_d, tmp, ext;
  logic [FW-1:0]       fill_q, fill_d, c, f_rem, r;
  st_e                 st_q, st_d;
  logic                acc, cons;

  function automatic st_e next_st(input logic [FW-1:0] f);
    if (f == '0)      return EMPTY;
    else if (f < W_F) return FILLING;
    else              return FULL;
  endfunction

  assign rdy_o  = (st_q != FLUSH) && (fill_q <= W_F);
  assign vld_o  = (st_q == FULL);
  assign idle_o = (st_q == EMPTY) && !vld_i;
  assign data_o = buf_q[2*DATA_W-1:DATA_W];
  assign fill_o = fill_q;

  assign acc   = vld_i && rdy_o;
  assign cons  = vld_o && rdy_i;
  assign c     = cons ? FW'(consume_i) : '0;
  assign f_rem = fill_q - c;
  assign tmp   = buf_q << c;
  // New word lands directly below the bits that survive this cycle's consume.
  assign ext   = {data_i, {DATA_W{1'b0}}} >> f_rem;

  // Distance to the next input-word boundary (fill_q mod DATA_W).
  always_comb begin
    if (fill_q >= W2_F)     r = '0;
    else if (fill_q >= W_F) r = fill_q - W_F;
    else                    r = fill_q;
  end

  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    st_d   = st_q;
    if (st_q == FLUSH) begin
      buf_d  = buf_q << r;
      fill_d = fill_q - r;
      st_d   = next_st(fill_q - r);
    end else if (flush_i && st_q != EMPTY) begin
      st_d = FLUSH;
    end else if (acc) begin
      buf_d  = tmp | ext;
      fill_d = f_rem + W_F;
      st_d   = next_st(f_rem + W_F);
    end else begin
      buf_d  = tmp;
      fill_d = f_rem;
      st_d   = next_st(f_rem);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      fill_q <= '0;
      st_q   <= EMPTY;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      st_q   <= st_d;
    end
  end

`ifdef UNPACK_STREAMER_ASSERT_EN
  logic stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= vld_i && !rdy_o;
      assert (consume_i <= CW'(DATA_W))
        else $error("%0t: consume_i exceeds DATA_W", $time);
      assert (!cons || FW'(consume_i) <= fill_q)
        else $error("%0t: consume_i exceeds fill", $time);
      assert ((buf_q << fill_q) == '0)
        else $error("%0t: stale bits below fill", $time);
      assert ((fill_q == '0) == (st_q == EMPTY))
        else $error("%0t: fill/state disagree", $time);
      assert (!stall_q || vld_i)
        else $error("%0t: vld_i dropped while stalled", $time);
    end
  end
`endif

endmodule

// File: tb/tb_unshift_streamer.sv
// Randomized bench for unshift_streamer against a bit-queue reference model.
module tb_unshift_streamer;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
  localparam int FW = $clog2(2*W+1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          vld_i = 1'b0;
  logic          rdy_o;
  logic [W-1:0]  data_o;
  logic          vld_o;
  logic [CW-1:0] consume_i = '0;
  logic          rdy_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [FW-1:0] fill_o;
  logic          idle_o;

  unshift_streamer #(.DATA_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .vld_i(vld_i),
    .rdy_o(rdy_o), .data_o(data_o), .vld_o(vld_o), .consume_i(consume_i),
    .rdy_i(rdy_i), .flush_i(flush_i), .fill_o(fill_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: unconsumed bits in arrival order, plus a pending-flush flag.
  bit mq[$];
  bit mflush;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] m_data();
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < W; i++) d[W-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return d;
  endfunction

  function automatic logic m_vld(); return !mflush && mq.size() >= W; endfunction
  function automatic logic m_rdy(); return !mflush && mq.size() <= W; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("data_o", 32'(data_o), 32'(m_data()));
    chk("vld_o",  32'(vld_o),  32'(m_vld()));
    chk("rdy_o",  32'(rdy_o),  32'(m_rdy()));
    chk("fill_o", 32'(fill_o), 32'(mq.size()));
    chk("idle_o", 32'(idle_o), 32'(!mflush && mq.size() == 0 && !vld_i));
  endtask

  task automatic model_step();
    int  sz;
    bit  acc, con;
    sz = mq.size();
    if (mflush) begin
      repeat (sz % W) void'(mq.pop_front());
      mflush = 1'b0;
    end else if (flush_i && sz > 0) begin
      mflush = 1'b1;
    end else begin
      acc = vld_i && (sz <= W);
      con = rdy_i && (sz >= W);
      if (con) repeat (int'(consume_i)) void'(mq.pop_front());
      if (acc) for (int i = W-1; i >= 0; i--) mq.push_back(data_i[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic [W-1:0] d, input logic v, input int c,
                       input logic r, input logic f);
    data_i = d; vld_i = v; consume_i = CW'(c); rdy_i = r; flush_i = f;
  endtask

  initial begin
    mflush = 1'b0;
    #1;
    compare();
    chk("reset rdy_o", 32'(rdy_o), 32'd1);
    chk("reset idle_o", 32'(idle_o), 32'd1);
    #6 rst_ni = 1'b1;

    drive(8'hA5, 1, 0, 0, 0); cyc();
    chk("tp1 data", 32'(data_o), 32'hA5);
    chk("tp1 fill", 32'(fill_o), 32'd8);
    chk("tp1 vld", 32'(vld_o), 32'd1);
    drive(8'h3C, 1, 3, 1, 0); cyc();
    chk("tp2 data", 32'(data_o), 32'h29);
    chk("tp2 fill", 32'(fill_o), 32'd13);
    chk("tp2 rdy", 32'(rdy_o), 32'd0);
    drive(8'h00, 0, 5, 1, 0); cyc();
    chk("tp3 data", 32'(data_o), 32'h3C);
    drive(8'h00, 0, 8, 1, 0); cyc();
    chk("tp3 fill", 32'(fill_o), 32'd0);
    chk("tp3 idle", 32'(idle_o), 32'd1);

    drive(8'hFF, 1, 0, 0, 0); cyc();
    drive(8'h00, 0, 3, 1, 0); cyc();
    chk("tp4 fill5", 32'(fill_o), 32'd5);
    chk("tp4 vld", 32'(vld_o), 32'd0);
    drive(8'h00, 0, 0, 0, 1); cyc();
    chk("tp4 flush rdy", 32'(rdy_o), 32'd0);
    drive(8'h00, 0, 0, 0, 0); cyc();
    chk("tp4 fill0", 32'(fill_o), 32'd0);
    chk("tp4 data", 32'(data_o), 32'h00);

    drive(8'h11, 1, 8, 1, 0); cyc(); chk("tp5 w0", 32'(data_o), 32'h11);
    drive(8'h22, 1, 8, 1, 0); cyc(); chk("tp5 w1", 32'(data_o), 32'h22);
    drive(8'h33, 1, 8, 1, 0); cyc(); chk("tp5 w2", 32'(data_o), 32'h33);
    chk("tp5 vld", 32'(vld_o), 32'd1);
    drive(8'h00, 0, 8, 1, 0); cyc();

    drive(8'hAA, 1, 0, 0, 0); cyc();
    drive(8'hBB, 1, 4, 1, 0); cyc();
    chk("tp6 fill12", 32'(fill_o), 32'd12);
    drive(8'h00, 0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    mq.delete();
    mflush = 1'b0;
    chk("tp6 rst fill", 32'(fill_o), 32'd0);
    chk("tp6 rst vld", 32'(vld_o), 32'd0);
    chk("tp6 rst rdy", 32'(rdy_o), 32'd1);
    compare();
    #2 rst_ni = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      drive(W'($urandom), ($urandom % 4) != 0, int'($urandom_range(0, W)),
            ($urandom % 3) != 0, ($urandom % 16) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
